vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator, successor to the fixed 640x480 colour-bar display block. Derives a pixel enable from the system clock, generates programmable-polarity HSYNC/VSYNC with fully parametrised porch and sync timing, and drives one of four selectable patterns on a parametrised-width RGB bus. It exports pixel coordinates, display-enable and frame-start for downstream overlay and frame-buffer readers.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); 2 gives 25 MHz pixels from 50 MHz
H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
HS_POL, 0, HSYNC active level (0 = active-low)
VS_POL, 0, VSYNC active level
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 bars, 1 checker, 2 grid, 3 solid
solid_rgb  in  3*COLOR_W  colour for mode 3, {R,G,B}
VGA_HSYNC  out  1  line sync
VGA_VSYNC  out  1  frame sync
VGA_D  out  3*COLOR_W  pixel colour {R,G,B}
de  out  1  display enable, high during active pixels
pix_x  out  11  column of the pixel currently on VGA_D
pix_y  out  11  row of the pixel currently on VGA_D
frame_start  out  1  one-clk pulse at first active pixel of each frame

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low, reset_n. All state is reset asynchronously and all outputs are registered.
- Reset values: VGA_HSYNC=~HS_POL, VGA_VSYNC=~VS_POL, VGA_D=0, de=0, pix_x=0, pix_y=0, frame_start=0. Counters, divider and latched mode are 0.
- Pixel enable pe: divider counts 0..CLK_DIV-1, pe=1 when count==CLK_DIV-1. With CLK_DIV=1, pe is constantly 1. All counters and outputs change only on pe cycles.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL equivalent. hcnt runs 0..H_TOTAL-1 and wraps to 0, giving exactly H_TOTAL pixels per line. vcnt increments when hcnt wraps and itself wraps after V_TOTAL-1.
- Sync: HSYNC is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), otherwise idle. VSYNC is active for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines, and is registered, not combinational.
- Latency: on each pe, outputs take the values decoded from the pre-increment (hcnt,vcnt). Sync, de, pix_x/y and VGA_D are mutually aligned, with one pixel period of latency from the counters.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE. Outside it, VGA_D=0 and de=0; pix_x/pix_y hold their last value.
- Mode latch: mode is sampled into an internal register only at hcnt==0, vcnt==0. Mid-frame changes take effect at the next frame.
- Pattern 0, colour bars: 8 bars, each H_ACTIVE/8 wide. The bar index b is kept by a bar-width counter, with no divider. Each channel is all-ones or 0: R=b[0], G=b[1], B=b[2]. Bar 0 is black, bar 7 is white.
- Pattern 1, checker: 32x32 squares. White when x[5]^y[5]=1, else black.
- Pattern 2, grid: white when x[4:0]==0, y[4:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1. Otherwise blue at mid-scale (MSB set only).
- Pattern 3, solid: VGA_D=solid_rgb, sampled on every active pixel; no latch.
- frame_start: high for exactly one clk, on the pe cycle outputting pixel (0,0).
- Reset mid-frame: all outputs return to reset values immediately. Counting restarts at (0,0) on the first pe after release.

Test Plan:
- CLK_DIV=2, defaults, mode 0: the HSYNC period must be 1600 clk with a low pulse of 192 clk starting 1312 clk after the pixel-0 edge. The VSYNC period must be 525 lines with a 2-line low pulse starting at line 490.
- mode 0, row 0: VGA_D must be 0x000 for x 0..79, 0xF00 for x 80..159, 0x0F0 for x 160..239, and 0xFFF for x 560..639. VGA_D must be 0 at x=640.
- Small timing (H 16/2/2/2, V 8/1/1/1, CLK_DIV=1): de count per frame must be 128, and frame_start must occur every 22*11=242 clk, each time with pix_x=pix_y=0.
- Switch mode 0->1 at line 100: output must stay bars until frame end. Pixel (32,0) of the next frame must be 0xFFF and (32,32) must be 0x000.
- mode 3, solid_rgb=0x5A3: every active pixel must be 0x5A3 and every blanking pixel 0. HS_POL=1 must invert VGA_HSYNC only.
- Assert reset_n low mid-line at (300,200): outputs must go to reset values asynchronously. After release, the first frame_start must come after exactly one pe.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator with parametrised porches, sync polarity and colour depth.
// Outputs are registered and aligned one pixel period after the raster counters.
module vga_pattern_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   VGA_HSYNC,
    output logic                   VGA_VSYNC,
    output logic [3*COLOR_W-1:0]   VGA_D,
    output logic                   de,
    output logic [10:0]            pix_x,
    output logic [10:0]            pix_y,
    output logic                   frame_start
);
    localparam int unsigned CW      = 11;
    localparam int unsigned RGB_W   = 3 * COLOR_W;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]      H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]      V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]      H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]      V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]      H_EDGE   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0]      V_EDGE   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0]      HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]      HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]      VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]      VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BAR_CW-1:0]  BAR_LAST = BAR_CW'(BAR_W - 1);
    localparam logic [COLOR_W-1:0] C_MID    = COLOR_W'(1 << (COLOR_W - 1));

    logic [DIV_W-1:0]  div_q, div_d;
    logic              pe;
    logic [CW-1:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [BAR_CW-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [1:0]        mode_q, mode_d, cur_mode;
    logic              origin, active, grid_line;
    logic [RGB_W-1:0]  pattern;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic [CW-1:0]     pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    assign pe        = (div_q == DIV_LAST);
    assign origin    = (hcnt_q == '0) && (vcnt_q == '0);
    assign active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    // The mode sampled at (0,0) already applies to pixel (0,0) itself.
    assign cur_mode  = origin ? mode : mode_q;
    assign grid_line = (hcnt_q[4:0] == 5'd0) || (vcnt_q[4:0] == 5'd0) ||
                       (hcnt_q == H_EDGE) || (vcnt_q == V_EDGE);

    always_comb begin
        div_d     = pe ? '0 : div_q + 1'b1;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        mode_d    = mode_q;
        if (pe) begin
            if (origin) mode_d = mode;
            if (hcnt_q == H_LAST) begin
                hcnt_d    = '0;
                vcnt_d    = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
                bar_pos_d = '0;
                bar_idx_d = '0;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
                // Bar index tracks hcnt / BAR_W without a divider.
                if (hcnt_q < H_ACT) begin
                    if (bar_pos_q == BAR_LAST) begin
                        bar_pos_d = '0;
                        bar_idx_d = bar_idx_q + 1'b1;
                    end else begin
                        bar_pos_d = bar_pos_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pattern = '0;
        case (cur_mode)
            2'd0:    pattern = {{COLOR_W{bar_idx_q[0]}}, {COLOR_W{bar_idx_q[1]}},
                                {COLOR_W{bar_idx_q[2]}}};
            2'd1:    pattern = (hcnt_q[5] ^ vcnt_q[5]) ? '1 : '0;
            2'd2:    pattern = grid_line ? '1 : {{(2 * COLOR_W){1'b0}}, C_MID};
            default: pattern = solid_rgb;
        endcase
    end

    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        rgb_d   = rgb_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        fs_d    = 1'b0;
        if (pe) begin
            hs_d  = (hcnt_q >= HS_START && hcnt_q < HS_END) ? HS_POL : ~HS_POL;
            vs_d  = (vcnt_q >= VS_START && vcnt_q < VS_END) ? VS_POL : ~VS_POL;
            de_d  = active;
            rgb_d = active ? pattern : '0;
            fs_d  = origin;
            if (active) begin
                pix_x_d = hcnt_q;
                pix_y_d = vcnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            rgb_q     <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            fs_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            rgb_q     <= rgb_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            fs_q      <= fs_d;
        end
    end

    assign VGA_HSYNC   = hs_q;
    assign VGA_VSYNC   = vs_q;
    assign VGA_D       = rgb_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: default 640x480 timing plus two reduced rasters
// (22x11 with active-high HSYNC, 76x54) so whole frames fit in a short run.
module tb_vga_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [1:0]  mode_def = 2'd0, mode_sml = 2'd0, mode_med = 2'd0;
    logic [11:0] solid_def = 12'h000, solid_sml = 12'h000, solid_med = 12'h000;
    logic        hs_def, vs_def, de_def, fs_def;
    logic        hs_sml, vs_sml, de_sml, fs_sml;
    logic        hs_med, vs_med, de_med, fs_med;
    logic [11:0] d_def, d_sml, d_med;
    logic [10:0] x_def, y_def, x_sml, y_sml, x_med, y_med;

    vga_pattern_gen u_def (
        .clk(clk), .reset_n(reset_n), .mode(mode_def), .solid_rgb(solid_def),
        .VGA_HSYNC(hs_def), .VGA_VSYNC(vs_def), .VGA_D(d_def), .de(de_def),
        .pix_x(x_def), .pix_y(y_def), .frame_start(fs_def)
    );

    vga_pattern_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_sml (
        .clk(clk), .reset_n(reset_n), .mode(mode_sml), .solid_rgb(solid_sml),
        .VGA_HSYNC(hs_sml), .VGA_VSYNC(vs_sml), .VGA_D(d_sml), .de(de_sml),
        .pix_x(x_sml), .pix_y(y_sml), .frame_start(fs_sml)
    );

    vga_pattern_gen #(
        .CLK_DIV(1), .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_med (
        .clk(clk), .reset_n(reset_n), .mode(mode_med), .solid_rgb(solid_med),
        .VGA_HSYNC(hs_med), .VGA_VSYNC(vs_med), .VGA_D(d_med), .de(de_med),
        .pix_x(x_med), .pix_y(y_med), .frame_start(fs_med)
    );

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Returns the cycle of the next frame_start of instance 0/1/2, or -1 on timeout.
    task automatic wait_fs(input int which, output int t);
        int   n;
        logic seen;
        n = 0;
        t = -1;
        while (n < 20000) begin
            seen = (which == 0) ? fs_def : (which == 1) ? fs_sml : fs_med;
            if (seen === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({hs_def, vs_def, d_def, de_def, x_def, y_def, fs_def} !== {1'b1, 1'b1, 12'h000,
            1'b0, 11'd0, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_def: got hs=%b vs=%b rgb=%03h de=%b x=%0d y=%0d fs=%b, required 1 1 000 0 0 0 0",
                     hs_def, vs_def, d_def, de_def, x_def, y_def, fs_def);
        end
        checks++;
        if ({hs_sml, vs_sml, d_sml, de_sml, fs_sml} !== {1'b0, 1'b1, 12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hspol1: got hs=%b vs=%b rgb=%03h de=%b fs=%b, required 0 1 000 0 0",
                     hs_sml, vs_sml, d_sml, de_sml, fs_sml);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_def_line();
        int          t0;
        int          xs [9];
        logic [11:0] ed [9];
        logic        ede [9];
        int          ex [9];
        int          hoff [6];
        logic        hexp [6];
        xs   = '{79, 80, 159, 160, 239, 400, 560, 639, 640};
        ed   = '{12'h000, 12'hF00, 12'hF00, 12'h0F0, 12'h0F0, 12'hF0F, 12'hFFF, 12'hFFF, 12'h000};
        ede  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex   = '{79, 80, 159, 160, 239, 400, 560, 639, 639};
        hoff = '{1311, 1312, 1503, 1504, 2911, 2912};
        hexp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        mode_def = 2'd0;
        do_reset();
        wait_fs(0, t0);
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL def_frame_start: got none, required a pulse after reset");
            return;
        end
        checks++;
        if ({d_def, de_def, x_def, y_def} !== {12'h000, 1'b1, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL def_pixel0: got rgb=%03h de=%b x=%0d y=%0d, required 000 1 0 0",
                     d_def, de_def, x_def, y_def);
        end
        wait_cyc(t0 + 1);
        checks++;
        if (fs_def !== 1'b0) begin
            errors++;
            $display("FAIL def_fs_width: got fs=%b one clk later, required 0", fs_def);
        end
        for (int i = 0; i < 9; i++) begin
            wait_cyc(t0 + 2 * xs[i]);
            checks++;
            if (d_def !== ed[i] || de_def !== ede[i] || x_def !== 11'(ex[i]) || y_def !== 11'd0) begin
                errors++;
                $display("FAIL bars_row0 x=%0d: got rgb=%03h de=%b x=%0d y=%0d, required rgb=%03h de=%b x=%0d y=0",
                         xs[i], d_def, de_def, x_def, y_def, ed[i], ede[i], ex[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            wait_cyc(t0 + hoff[i]);
            checks++;
            if (hs_def !== hexp[i] || vs_def !== 1'b1) begin
                errors++;
                $display("FAIL def_hsync clk+%0d: got hs=%b vs=%b, required hs=%b vs=1",
                         hoff[i], hs_def, vs_def, hexp[i]);
            end
        end
    endtask

    task automatic test_small_timing();
        int t0;
        int de_n;
        int fs_n;
        int soff [8];
        logic sexp [8];
        logic ssel [8];
        de_n = 0;
        fs_n = 0;
        soff = '{259, 260, 261, 262, 439, 440, 461, 462};
        sexp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ssel = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        mode_sml = 2'd0;
        do_reset();
        wait_fs(1, t0);
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL sml_frame_start: got none, required a pulse after reset");
            return;
        end
        for (int k = 0; k < 242; k++) begin
            wait_cyc(t0 + k);
            de_n += int'(de_sml);
            fs_n += int'(fs_sml);
        end
        checks++;
        if (de_n != 128 || fs_n != 1) begin
            errors++;
            $display("FAIL sml_frame_counts: got de=%0d fs=%0d, required de=128 fs=1", de_n, fs_n);
        end
        wait_cyc(t0 + 242);
        checks++;
        if ({fs_sml, x_sml, y_sml} !== {1'b1, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL sml_fs_period: got fs=%b x=%0d y=%0d at clk+242, required 1 0 0",
                     fs_sml, x_sml, y_sml);
        end
        for (int i = 0; i < 8; i++) begin
            wait_cyc(t0 + soff[i]);
            checks++;
            if ((ssel[i] ? vs_sml : hs_sml) !== sexp[i]) begin
                errors++;
                $display("FAIL sml_sync clk+%0d %s: got %b, required %b", soff[i],
                         ssel[i] ? "vsync" : "hsync", ssel[i] ? vs_sml : hs_sml, sexp[i]);
            end
        end
        wait_cyc(t0 + 484);
        checks++;
        if ({fs_sml, x_sml, y_sml} !== {1'b1, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL sml_fs_period2: got fs=%b x=%0d y=%0d at clk+484, required 1 0 0",
                     fs_sml, x_sml, y_sml);
        end
    endtask

    task automatic test_solid();
        int t0;
        int bad;
        int o;
        bad = 0;
        mode_sml  = 2'd3;
        solid_sml = 12'h5A3;
        do_reset();
        wait_fs(1, t0);
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL solid_frame_start: got none, required a pulse after reset");
            return;
        end
        for (int k = 0; k < 242; k++) begin
            wait_cyc(t0 + k);
            if (de_sml ? (d_sml !== 12'h5A3) : (d_sml !== 12'h000)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL solid_frame: got %0d wrong pixels, required 0", bad);
        end
        o = t0 + 242 + 2 * 22 + 5;
        wait_cyc(o);
        solid_sml = 12'h3C1;
        wait_cyc(o + 1);
        checks++;
        if (d_sml !== 12'h3C1) begin
            errors++;
            $display("FAIL solid_live: got rgb=%03h after solid change, required 3c1", d_sml);
        end
    endtask

    // sel: 0 = VGA_D, 1 = VSYNC, 2 = frame_start, 3 = drive mode (no check).
    task automatic test_mode_switch();
        int t0;
        int off [24];
        int sel [24];
        int val [24];
        int got;
        off = '{32, 64, 1525, 2464, 3048, 3799, 3800, 3951, 3952, 4103, 4104, 4104,
                4136, 6536, 6568, 7904, 7950, 8208, 8285, 8651, 8772, 10647, 10749, 11785};
        sel = '{0, 0, 3, 0, 0, 1, 1, 1, 1, 2, 2, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0};
        val = '{'h00F, 'h000, 1, 'h00F, 'hF00, 1, 0, 0, 1, 0, 1, 'h000, 'hFFF, 'hFFF,
                'h000, 0, 2, 'hFFF, 'h008, 'hFFF, 'hFFF, 'hFFF, 'h008, 'hFFF};
        mode_med = 2'd0;
        do_reset();
        wait_fs(2, t0);
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL med_frame_start: got none, required a pulse after reset");
            return;
        end
        for (int i = 0; i < 24; i++) begin
            wait_cyc(t0 + off[i]);
            if (sel[i] == 3) begin
                mode_med = 2'(val[i]);
            end else begin
                got = (sel[i] == 0) ? int'(d_med) : (sel[i] == 1) ? int'(vs_med) : int'(fs_med);
                checks++;
                if (got != val[i]) begin
                    errors++;
                    $display("FAIL med_raster clk+%0d sel=%0d (x=%0d y=%0d): got %03h, required %03h",
                             off[i], sel[i], x_med, y_med, got, val[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        mode_med = 2'd0;
        do_reset();
        wait_fs(2, t0);
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL rst_frame_start: got none, required a pulse after reset");
            return;
        end
        wait_cyc(t0 + 76 * 20 + 30);
        checks++;
        if ({d_med, de_med, x_med, y_med} !== {12'hFF0, 1'b1, 11'd30, 11'd20}) begin
            errors++;
            $display("FAIL rst_before: got rgb=%03h de=%b x=%0d y=%0d, required ff0 1 30 20",
                     d_med, de_med, x_med, y_med);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({hs_med, vs_med, d_med, de_med, x_med, y_med, fs_med} !== {1'b1, 1'b1, 12'h000,
            1'b0, 11'd0, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_async: got hs=%b vs=%b rgb=%03h de=%b x=%0d y=%0d fs=%b, required 1 1 000 0 0 0 0",
                     hs_med, vs_med, d_med, de_med, x_med, y_med, fs_med);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({fs_med, de_med, x_med, y_med, fs_def} !== {1'b1, 1'b1, 11'd0, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_first_pe: got med fs=%b de=%b x=%0d y=%0d def fs=%b, required 1 1 0 0 0",
                     fs_med, de_med, x_med, y_med, fs_def);
        end
        @(negedge clk);
        checks++;
        if ({fs_med, fs_def} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_div2_pe: got med fs=%b def fs=%b, required 0 1", fs_med, fs_def);
        end
    endtask

    initial begin
        test_reset();
        test_def_line();
        test_small_timing();
        test_solid();
        test_mode_switch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
